serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   Inverse of the 4-bit ripple carry adder; shares operand/carry naming.
//   Sits in the datapath where area outweighs latency.
//   start/busy/done handshake: captures operands, streams WIDTH cycles, presents result.
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>=2)
// PORTS
//   clk    in   1      single clock; all logic on posedge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only when not busy
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow-in, captured on accepted start
//   busy   out  1      high while shifting
//   done   out  1      one-cycle pulse, result valid
//   diff   out  WIDTH  a - b - bin mod 2^WIDTH, held until next accepted start
//   bout   out  1      borrow-out (1 when a < b + bin unsigned), held with diff
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift regs, borrow, count=0.
//   - FSM: IDLE -start-> BUSY; BUSY -(count==WIDTH-1)-> DONE; DONE -start-> BUSY, else IDLE.
//   - Accept: start in IDLE or DONE loads a,b into shift regs, bin into borrow flop, count=0.
//   - BUSY cycle, on LSBs x=a_sr[0], y=b_sr[0], br=borrow:
//       d = x^y^br; br' = (~x&y) | (~(x^y)&br).
//       d enters result reg at MSB, result shifts right; a_sr, b_sr shift right; count++.
//   - Final BUSY cycle: diff <= completed result, bout <= br'; next state DONE.
//   - Latency: start sampled at edge T -> done=1 during cycle after edge T+WIDTH.
//   - Throughput: start in DONE gives one result per WIDTH+1 cycles.
//   - start while BUSY: ignored, no effect on operands or count.
//   - diff/bout change only on the final BUSY edge; stable in IDLE/DONE and early BUSY.
//   - done is exactly one cycle, even if start is held.
//   - Reset mid-operation: abort immediately to reset values, no done pulse.
//   - No X propagation: a/b/bin are don't-care unless start is accepted.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined: adds output ovf (1 bit, reset 0), updated with diff.
//     ovf = 1 when the signed two's-complement result overflows:
//     ovf = br_in_msb ^ br_out_msb on the MSB step.
//   Not defined: no ovf port, no extra logic.
// STRUCTURE
//   Package serial_sub_pkg:
//     state localparams S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2;
//     function clog2 for the count width.
//   Sub-module full_subtractor (x, y, bin -> d, bout), one instance in the serial datapath.
//   Top holds the FSM, shift registers, counter and output registers.
// TESTING (WIDTH=4)
//   1. a=0000 b=0000 bin=1 -> after 5 cycles done=1, diff=1111, bout=1.
//   2. a=1001 b=0011 bin=0 -> diff=0110, bout=0; busy high exactly 4 cycles.
//   3. a=0100 b=1111 bin=0 -> diff=0101, bout=1.
//   4. Back-to-back: start held.
//        Result a=1111,b=0000,bin=1 -> 1110/0.
//        Then a=0000,b=0111,bin=0 -> 1001/1, done pulses 5 cycles apart.
//   5. start pulsed with new operands mid-BUSY -> ignored, result matches first operands.
//   6. rst at 2nd BUSY cycle -> next cycle busy=0, done=0, diff=0, bout=0; no done pulse.
//   OVF_EN: a=1000 b=0001 bin=0 -> diff=0111, ovf=1.
//   OVF_EN: a=0011 b=0001 bin=0 -> diff=0010, ovf=0.
//   Random: 1000 operand sets vs a-b-bin reference model, all WIDTH in {4, 8}.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared FSM state encoding and width helper for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             borrow;
    logic [CNT_W-1:0] count;
    logic             accept, last_step;
    logic             fs_d, fs_bout;

    full_subtractor u_full_subtractor (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (count == LAST_CNT) begin
                    last_step  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_BUSY;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                borrow <= bin;
                count  <= '0;
            end else if (state == S_BUSY) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {fs_d, res_sr[WIDTH-1:1]};
                borrow <= fs_bout;
                count  <= count + CNT_W'(1);
                // Outputs only move on the MSB step so they stay stable otherwise.
                if (last_step) begin
                    diff <= {fs_d, res_sr[WIDTH-1:1]};
                    bout <= fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf  <= borrow ^ fs_bout;
`endif
                end
            end
        end
    end

    always_comb begin
        busy = (state == S_BUSY);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases plus random operands.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic             busy, done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               checks   = 0;
    int               failures = 0;
    logic             rst_d    = 1'b1;
    logic [WIDTH-1:0] diff_d   = '0;

    // Reference: plain integer arithmetic, unsigned for diff/bout, signed for ovf.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mbin);
        exp_t e;
        int   full, sa, sbv, sr;
        full   = int'(ma) - int'(mb) - int'(mbin);
        e.diff = full[WIDTH-1:0];
        e.bout = (full < 0);
        sa     = ma[WIDTH-1] ? int'(ma) - (1 << WIDTH) : int'(ma);
        sbv    = mb[WIDTH-1] ? int'(mb) - (1 << WIDTH) : int'(mb);
        sr     = sa - sbv - int'(mbin);
        e.ovf  = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t",
                         $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("diff", 32'(diff), 32'(mon_e.diff));
                check("bout", 32'(bout), 32'(mon_e.bout));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
            end
        end
        if (!rst && !rst_d && (diff !== diff_d)) begin
            check("diff_changes_only_with_done", 32'(done), 32'd1);
        end
        rst_d  = rst;
        diff_d = diff;
    end

    task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                          input logic obin, input bit inject);
        int cyc, bcnt;
        bit got;
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = oa;
        b     = ob;
        bin   = obin;
        sb_q.push_back(model(oa, ob, obin));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
        cyc   = 0;
        bcnt  = 0;
        got   = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            cyc++;
            if (busy) bcnt++;
            if (inject && cyc == 2) begin
                start = 1'b1;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                bin   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(cyc), 32'(WIDTH));
        check("busy_cycles", 32'(bcnt), 32'(WIDTH));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap;
        bit got;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        run_op(WIDTH'(4'b0000), WIDTH'(4'b0000), 1'b1, 1'b0);
        run_op(WIDTH'(4'b1001), WIDTH'(4'b0011), 1'b0, 1'b0);
        run_op(WIDTH'(4'b0100), WIDTH'(4'b1111), 1'b0, 1'b0);
        run_op(WIDTH'(4'b0110), WIDTH'(4'b0010), 1'b1, 1'b1);
        run_op(WIDTH'(4'b1000), WIDTH'(4'b0001), 1'b0, 1'b0);
        run_op(WIDTH'(4'b0011), WIDTH'(4'b0001), 1'b0, 1'b0);

        // Back-to-back with start held high through DONE.
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = WIDTH'(4'b1111);
        b     = WIDTH'(4'b0000);
        bin   = 1'b1;
        sb_q.push_back(model(a, b, bin));
        @(posedge clk);
        #1;
        a   = WIDTH'(4'b0000);
        b   = WIDTH'(4'b0111);
        bin = 1'b0;
        sb_q.push_back(model(a, b, bin));
        got = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b_first_done", 32'(got), 32'd1);
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            gap++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("b2b_second_done", 32'(got), 32'd1);
        check("b2b_spacing", 32'(gap), 32'(WIDTH + 1));

        // Reset during the second BUSY cycle aborts without a done pulse.
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = WIDTH'(4'b1010);
        b     = WIDTH'(4'b0101);
        bin   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        repeat (3 * WIDTH) @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
